// File: rtl/seg7_scan_mux_pkg.sv
// seg7_scan_mux_pkg
//   Shared definitions for the multiplexed 7-segment display driver:
//   segment bit positions, the per-digit buffer record, the slot phase
//   type and a constant-evaluable clog2.
package seg7_scan_mux_pkg;

    localparam int SEG_W = 7;

    // Bit positions inside a {g,f,e,d,c,b,a} pattern.
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // All segments dark (logical, before output polarity is applied).
    localparam logic [SEG_W-1:0] SEG_BLANK = '0;

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_DRIVE = 1'b1
    } phase_e;

    // One digit of the pending/active buffers.
    typedef struct packed {
        logic             blank;
        logic             dp;
        logic [SEG_W-1:0] seg;
    } digit_t;

    localparam digit_t DIGIT_DARK = '{blank: 1'b1, dp: 1'b0, seg: SEG_BLANK};

    // Minimum of 1 so single-value ranges still get a usable bit.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/seg7_scan_mux_if.sv
// seg7_scan_mux_if
//   Bundles the pattern inputs, load strobe and display outputs of
//   seg7_scan_mux.
//   master: the producer of digit patterns (drives seg_in/dp_in/blank_in/load)
//   slave : the scan mux itself (drives pending and the display outputs)
interface seg7_scan_mux_if #(
    parameter int NUM_DIGITS = 4
);
    import seg7_scan_mux_pkg::*;

    localparam int IDX_W = clog2(NUM_DIGITS);

    logic [SEG_W*NUM_DIGITS-1:0] seg_in;
    logic [NUM_DIGITS-1:0]       dp_in;
    logic [NUM_DIGITS-1:0]       blank_in;
    logic                        load;
    logic                        pending;
    logic [SEG_W-1:0]            seg_out;
    logic                        dp_out;
    logic [NUM_DIGITS-1:0]       dig_en;
    logic [IDX_W-1:0]            digit_idx;
    logic                        frame_start;

    modport master (
        output seg_in, dp_in, blank_in, load,
        input  pending, seg_out, dp_out, dig_en, digit_idx, frame_start
    );

    modport slave (
        input  seg_in, dp_in, blank_in, load,
        output pending, seg_out, dp_out, dig_en, digit_idx, frame_start
    );

endinterface

// File: rtl/seg7_scan_mux_slot_timer.sv
// seg7_slot_timer
//   Slot timing for the scan mux: a prescale counter that divides each
//   digit slot into a blanking gap and a drive window, the digit index,
//   and the end-of-frame strobe.
//   clk, rst_n     : clock, asynchronous active-low reset
//   digit_idx_o    : registered index of the current slot
//   idx_nxt_o      : index that takes effect on the coming edge
//   phase_nxt_o    : BLANK/DRIVE phase that takes effect on the coming edge
//   wrap_o         : the coming edge ends the frame (last digit, last cycle)
//   frame_start_o  : registered one-cycle pulse in the first cycle of digit 0
//   The *_nxt outputs let the parent register its outputs on the same edge
//   as the counter so display and counter never disagree.
module seg7_slot_timer
    import seg7_scan_mux_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 500,
    localparam int IDX_W       = clog2(NUM_DIGITS)
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [IDX_W-1:0] digit_idx_o,
    output logic [IDX_W-1:0] idx_nxt_o,
    output phase_e           phase_nxt_o,
    output logic             wrap_o,
    output logic             frame_start_o
);

    localparam int               CNT_W     = clog2(PRESCALE);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             fs_q;
    logic             slot_end, frame_end;

    assign slot_end  = (cnt_q == CNT_LAST);
    assign frame_end = slot_end && (idx_q == IDX_LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (slot_end) begin
            cnt_d = '0;
            idx_d = frame_end ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            idx_q <= '0;
            fs_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            fs_q  <= frame_end;
        end
    end

    assign digit_idx_o   = idx_q;
    assign idx_nxt_o     = idx_d;
    assign phase_nxt_o   = (cnt_d < BLANK_END) ? PH_BLANK : PH_DRIVE;
    assign wrap_o        = frame_end;
    assign frame_start_o = fs_q;

endmodule

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux
//   Time-multiplexed 7-segment driver. Scans NUM_DIGITS decoded patterns
//   onto one shared segment bus with a per-digit enable, inserting a dark
//   gap at the start of every slot. New values land in a pending buffer
//   and are promoted to the active buffer only at the frame boundary, so
//   a frame is never shown half old / half new.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : seg7_scan_mux_if.slave
//                in : seg_in, dp_in, blank_in, load
//                out: pending, seg_out, dp_out, dig_en, digit_idx,
//                     frame_start (all registered)
module seg7_scan_mux
    import seg7_scan_mux_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int PRESCALE       = 50000,
    parameter int BLANK_CYCLES   = 500,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    seg7_scan_mux_if.slave bus
);

    localparam int IDX_W = clog2(NUM_DIGITS);

    // XOR masks that turn logical "lit/selected" into pin levels; they are
    // also the inactive pin levels.
    localparam logic                  DP_POL  = SEG_ACTIVE_LOW;
    localparam logic [SEG_W-1:0]      SEG_POL = {SEG_W{SEG_ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] DIG_POL = {NUM_DIGITS{DIG_ACTIVE_LOW}};

    logic [IDX_W-1:0] digit_idx, idx_nxt;
    phase_e           phase_nxt;
    logic             wrap, frame_start;

    seg7_slot_timer #(
        .NUM_DIGITS   (NUM_DIGITS),
        .PRESCALE     (PRESCALE),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk           (clk),
        .rst_n         (rst_n),
        .digit_idx_o   (digit_idx),
        .idx_nxt_o     (idx_nxt),
        .phase_nxt_o   (phase_nxt),
        .wrap_o        (wrap),
        .frame_start_o (frame_start)
    );

    // ---------------------------------------------------------------
    // Pending / active buffers
    // ---------------------------------------------------------------
    digit_t [NUM_DIGITS-1:0] in_dig;
    digit_t [NUM_DIGITS-1:0] pend_q, pend_d;
    digit_t [NUM_DIGITS-1:0] act_q, act_d;
    logic                    pending_q, pending_d;

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_unpack
        assign in_dig[k] = '{blank: bus.blank_in[k],
                             dp:    bus.dp_in[k],
                             seg:   bus.seg_in[SEG_W*k +: SEG_W]};
    end

    // The swap reads the old pending contents before a same-cycle load
    // overwrites them; that load then stays pending for the next frame.
    always_comb begin
        pend_d    = pend_q;
        act_d     = act_q;
        pending_d = pending_q;
        if (wrap && pending_q) begin
            act_d     = pend_q;
            pending_d = 1'b0;
        end
        if (bus.load) begin
            pend_d    = in_dig;
            pending_d = 1'b1;
        end
    end

    // ---------------------------------------------------------------
    // Output mux, computed from next-cycle timer state and the next
    // active buffer so the registered outputs match digit_idx exactly.
    // ---------------------------------------------------------------
    digit_t                cur;
    logic                  drive;
    logic [SEG_W-1:0]      seg_d, seg_q;
    logic                  dp_d, dp_q;
    logic [NUM_DIGITS-1:0] dig_d, dig_q;

    always_comb begin
        cur   = act_d[idx_nxt];
        drive = (phase_nxt == PH_DRIVE) && !cur.blank;
        seg_d = SEG_POL ^ (drive ? cur.seg : SEG_BLANK);
        dp_d  = DP_POL ^ (drive & cur.dp);
        dig_d = DIG_POL ^ (drive ? (NUM_DIGITS'(1) << idx_nxt) : '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q    <= {NUM_DIGITS{DIGIT_DARK}};
            act_q     <= {NUM_DIGITS{DIGIT_DARK}};
            pending_q <= 1'b0;
            seg_q     <= SEG_POL;
            dp_q      <= DP_POL;
            dig_q     <= DIG_POL;
        end else begin
            pend_q    <= pend_d;
            act_q     <= act_d;
            pending_q <= pending_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            dig_q     <= dig_d;
        end
    end

    assign bus.pending     = pending_q;
    assign bus.seg_out     = seg_q;
    assign bus.dp_out      = dp_q;
    assign bus.dig_en      = dig_q;
    assign bus.digit_idx   = digit_idx;
    assign bus.frame_start = frame_start;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// tb_seg7_scan_mux
//   Bench for seg7_scan_mux at NUM_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2,
//   both outputs active-low. A table of hand-derived checkpoints covers
//   the dark first frame, frame swap, blanking and load-on-wrap; random
//   loads are then checked every cycle against a cycle-count model, and
//   an asynchronous mid-frame reset is exercised at the end.
module tb_seg7_scan_mux;

    localparam int ND = 4;
    localparam int PS = 8;
    localparam int BC = 2;
    localparam int FRAME = ND * PS;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seg7_scan_mux_if #(.NUM_DIGITS(ND)) bus ();

    seg7_scan_mux #(
        .NUM_DIGITS     (ND),
        .PRESCALE       (PS),
        .BLANK_CYCLES   (BC),
        .SEG_ACTIVE_LOW (1'b1),
        .DIG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks = 0;
    int failures = 0;

    // ---------------- reference model ----------------
    // Cycle t since reset release fully determines slot and position; the
    // buffers follow the load/frame rules directly.
    int          t;
    logic [6:0]  m_as [ND];
    logic [6:0]  m_ps [ND];
    logic        m_ad [ND];
    logic        m_pd [ND];
    logic        m_ab [ND];
    logic        m_pb [ND];
    logic        m_pend;

    task automatic model_reset();
        t = 0;
        m_pend = 1'b0;
        for (int k = 0; k < ND; k++) begin
            m_as[k] = '0; m_ad[k] = 1'b0; m_ab[k] = 1'b1;
            m_ps[k] = '0; m_pd[k] = 1'b0; m_pb[k] = 1'b1;
        end
    endtask

    task automatic model_edge();
        if (((t + 1) % FRAME == 0) && m_pend) begin
            for (int k = 0; k < ND; k++) begin
                m_as[k] = m_ps[k]; m_ad[k] = m_pd[k]; m_ab[k] = m_pb[k];
            end
            m_pend = 1'b0;
        end
        if (bus.load) begin
            for (int k = 0; k < ND; k++) begin
                m_ps[k] = bus.seg_in[7*k +: 7];
                m_pd[k] = bus.dp_in[k];
                m_pb[k] = bus.blank_in[k];
            end
            m_pend = 1'b1;
        end
        t++;
    endtask

    function automatic logic [15:0] model_out();
        int   c, d;
        logic drv;
        logic [3:0] oh;
        c   = t % PS;
        d   = (t / PS) % ND;
        drv = (c >= BC) && !m_ab[d];
        oh  = 4'(1 << d);
        return {drv ? ~m_as[d] : 7'h7F,
                drv ? ~m_ad[d] : 1'b1,
                drv ? ~oh : 4'hF,
                2'(d),
                (t > 0) && (t % FRAME == 0),
                m_pend};
    endfunction

    function automatic logic [15:0] dut_out();
        return {bus.seg_out, bus.dp_out, bus.dig_en, bus.digit_idx,
                bus.frame_start, bus.pending};
    endfunction

    task automatic chk(input string name, input logic [15:0] got,
                       input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0d got=%h expected=%h", name, t, got, exp);
        end
    endtask

    // Called at a negedge with inputs already set; returns at the next negedge.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("model", dut_out(), model_out());
        @(negedge clk);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        int          cyc;
        bit          ld;
        logic [27:0] s;
        logic [3:0]  dp;
        logic [3:0]  bl;
        logic [6:0]  e_seg;
        logic        e_dp;
        logic [3:0]  e_dig;
        logic [1:0]  e_idx;
        logic        e_fs;
        logic        e_pend;
    } vec_t;

    function automatic vec_t mk(int cyc, bit ld, logic [27:0] s, logic [3:0] dp,
                                logic [3:0] bl, logic [6:0] es, logic edp,
                                logic [3:0] edg, logic [1:0] ei, logic efs,
                                logic ep);
        vec_t v;
        v.cyc = cyc; v.ld = ld; v.s = s; v.dp = dp; v.bl = bl;
        v.e_seg = es; v.e_dp = edp; v.e_dig = edg; v.e_idx = ei;
        v.e_fs = efs; v.e_pend = ep;
        return v;
    endfunction

    vec_t vt[$];

    initial begin
        logic [27:0] pa, py, px;
        int          guard;
        pa = {7'h3F, 7'h06, 7'h5B, 7'h4F};
        py = {4{7'h06}};
        px = {4{7'h5B}};

        // first frame dark; load A at cycle 3
        vt.push_back(mk(0,   0, 0,  0, 0,     7'h7F, 1, 4'hF, 0, 0, 0));
        vt.push_back(mk(2,   0, 0,  0, 0,     7'h7F, 1, 4'hF, 0, 0, 0));
        vt.push_back(mk(3,   1, pa, 0, 0,     7'h7F, 1, 4'hF, 0, 0, 0));
        vt.push_back(mk(4,   0, 0,  0, 0,     7'h7F, 1, 4'hF, 0, 0, 1));
        vt.push_back(mk(20,  0, 0,  0, 0,     7'h7F, 1, 4'hF, 2, 0, 1));
        vt.push_back(mk(31,  0, 0,  0, 0,     7'h7F, 1, 4'hF, 3, 0, 1));
        // A shown from cycle 32
        vt.push_back(mk(32,  0, 0,  0, 0,     7'h7F, 1, 4'hF, 0, 1, 0));
        vt.push_back(mk(33,  0, 0,  0, 0,     7'h7F, 1, 4'hF, 0, 0, 0));
        vt.push_back(mk(34,  0, 0,  0, 0,     7'h30, 1, 4'hE, 0, 0, 0));
        vt.push_back(mk(39,  0, 0,  0, 0,     7'h30, 1, 4'hE, 0, 0, 0));
        vt.push_back(mk(40,  0, 0,  0, 0,     7'h7F, 1, 4'hF, 1, 0, 0));
        vt.push_back(mk(42,  0, 0,  0, 0,     7'h24, 1, 4'hD, 1, 0, 0));
        vt.push_back(mk(50,  0, 0,  0, 0,     7'h79, 1, 4'hB, 2, 0, 0));
        vt.push_back(mk(58,  0, 0,  0, 0,     7'h40, 1, 4'h7, 3, 0, 0));
        vt.push_back(mk(64,  0, 0,  0, 0,     7'h7F, 1, 4'hF, 0, 1, 0));
        // load A with digit 2 blanked and dp on digit 0
        vt.push_back(mk(66,  1, pa, 4'b0001, 4'b0100, 7'h30, 1, 4'hE, 0, 0, 0));
        vt.push_back(mk(96,  0, 0,  0, 0,     7'h7F, 1, 4'hF, 0, 1, 0));
        vt.push_back(mk(98,  0, 0,  0, 0,     7'h30, 0, 4'hE, 0, 0, 0));
        // load Y, then X exactly on the wrap edge
        vt.push_back(mk(100, 1, py, 0, 0,     7'h30, 0, 4'hE, 0, 0, 0));
        vt.push_back(mk(106, 0, 0,  0, 0,     7'h24, 1, 4'hD, 1, 0, 1));
        vt.push_back(mk(114, 0, 0,  0, 0,     7'h7F, 1, 4'hF, 2, 0, 1));
        vt.push_back(mk(119, 0, 0,  0, 0,     7'h7F, 1, 4'hF, 2, 0, 1));
        vt.push_back(mk(122, 0, 0,  0, 0,     7'h40, 1, 4'h7, 3, 0, 1));
        vt.push_back(mk(127, 1, px, 0, 0,     7'h40, 1, 4'h7, 3, 0, 1));
        vt.push_back(mk(128, 0, 0,  0, 0,     7'h7F, 1, 4'hF, 0, 1, 1));
        vt.push_back(mk(130, 0, 0,  0, 0,     7'h79, 1, 4'hE, 0, 0, 1));
        vt.push_back(mk(146, 0, 0,  0, 0,     7'h79, 1, 4'hB, 2, 0, 1));
        vt.push_back(mk(160, 0, 0,  0, 0,     7'h7F, 1, 4'hF, 0, 1, 0));
        vt.push_back(mk(162, 0, 0,  0, 0,     7'h24, 1, 4'hE, 0, 0, 0));

        bus.seg_in = '0; bus.dp_in = '0; bus.blank_in = '0; bus.load = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_state", dut_out(), model_out());
        @(negedge clk);
        // one step already elapsed since release
        model_edge();
        #0;

        foreach (vt[i]) begin
            while (t < vt[i].cyc) step();
            chk($sformatf("vec%0d", vt[i].cyc), dut_out(),
                {vt[i].e_seg, vt[i].e_dp, vt[i].e_dig, vt[i].e_idx,
                 vt[i].e_fs, vt[i].e_pend});
            if (vt[i].ld) begin
                bus.seg_in = vt[i].s; bus.dp_in = vt[i].dp;
                bus.blank_in = vt[i].bl; bus.load = 1'b1;
                step();
                bus.load = 1'b0;
            end
        end

        // random loads, with extra weight on the wrap cycle
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(9) == 0 ||
                ((t % FRAME) == FRAME - 1 && $urandom_range(1) == 1)) begin
                bus.seg_in   = 28'($urandom);
                bus.dp_in    = 4'($urandom);
                bus.blank_in = 4'($urandom);
                bus.load     = 1'b1;
            end
            step();
            bus.load = 1'b0;
        end

        // asynchronous reset in the middle of a drive window, with data pending
        bus.seg_in = pa; bus.dp_in = '0; bus.blank_in = '0; bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        guard = 0;
        while (!(m_pend == 1'b0 && (t % FRAME) == 4) && guard < 200) begin
            step();
            guard++;
        end
        if (guard >= 200) begin
            checks++; failures++;
            $display("FAIL sync_to_drive t=%0d got=timeout expected=digit0 cnt4", t);
        end
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        chk("pre_rst_drive", {12'h0, bus.dig_en}, {12'h0, 4'hE});
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst", dut_out(), {7'h7F, 1'b1, 4'hF, 2'd0, 1'b0, 1'b0});
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_release", dut_out(), model_out());
        @(negedge clk);
        model_edge();
        for (int n = 0; n < 40; n++) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
